// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared state encoding and reset constants for the fetch stage
package fetch_unit_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HOLD, ST_HALT} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory and core-side signals of the fetch stage
interface fetch_unit_if #(parameter int ADDR_W = 32);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic              PCSrc;
  logic [ADDR_W-1:0] PCTarget;
  logic [31:0]       Instr;
  logic [6:0]        Op;
  logic [2:0]        funct3;
  logic              funct7;
  logic [ADDR_W-1:0] PC;
  logic [ADDR_W-1:0] PCPlus4;
  logic [31:0]       instret;
  logic              fetch_err;
  modport master (
    output imem_req, imem_addr, instr_valid, Instr, Op, funct3, funct7, PC, PCPlus4, instret, fetch_err,
    input  imem_rvalid, imem_rdata, instr_ready, PCSrc, PCTarget
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, Instr, Op, funct3, funct7, PC, PCPlus4, instret, fetch_err,
    output imem_rvalid, imem_rdata, instr_ready, PCSrc, PCTarget
  );
endinterface

// File: rtl/fetch_unit_pc_next_sel.sv
// pc_next_sel: PC+4, branch/jump next-PC mux and misaligned-target detection
module pc_next_sel #(parameter int ADDR_W = 32) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_pc_src,
  input  logic [ADDR_W-1:0] i_pc_target,
  output logic [ADDR_W-1:0] o_pc_plus4,
  output logic [ADDR_W-1:0] o_pc_next,
  output logic              o_misalign
);
  assign o_pc_plus4 = i_pc + ADDR_W'(4);
  assign o_pc_next  = i_pc_src ? i_pc_target : o_pc_plus4;
  assign o_misalign = i_pc_src & (|i_pc_target[1:0]);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with PC, instruction register and retire counter
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_pc, w_pc_plus4, w_pc_next;
  logic [31:0]       r_instr, r_instret;
  logic              r_err, w_misalign, w_retire;
  pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
    .i_pc        (r_pc),
    .i_pc_src    (bus.PCSrc),
    .i_pc_target (bus.PCTarget),
    .o_pc_plus4  (w_pc_plus4),
    .o_pc_next   (w_pc_next),
    .o_misalign  (w_misalign)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_pc      <= RESET_PC;
      r_instr   <= NOP_INSTR;
      r_instret <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_FETCH && bus.imem_rvalid) r_instr <= bus.imem_rdata;
      if (w_retire) begin
        r_instret <= r_instret + 32'd1;
        if (w_misalign) r_err <= 1'b1;
        else r_pc <= w_pc_next;
      end
    end
  end
  always_comb begin
    w_retire = (r_state == ST_HOLD) && bus.instr_ready;
    w_next   = r_state;
    case (r_state)
      ST_IDLE:  w_next = ST_FETCH;
      ST_FETCH: w_next = bus.imem_rvalid ? ST_HOLD : ST_FETCH;
      ST_HOLD:  w_next = !w_retire ? ST_HOLD : (w_misalign ? ST_HALT : ST_FETCH);
      default:  w_next = ST_HALT;
    endcase
  end
  assign bus.imem_req    = r_state == ST_FETCH;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = r_state == ST_HOLD;
  assign bus.Instr       = r_instr;
  assign bus.Op          = r_instr[6:0];
  assign bus.funct3      = r_instr[14:12];
  assign bus.funct7      = r_instr[30];
  assign bus.PC          = r_pc;
  assign bus.PCPlus4     = w_pc_plus4;
  assign bus.instret     = r_instret;
  assign bus.fetch_err   = r_err;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for the fetch stage
module tb_fetch_unit;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_tot;
  fetch_unit_if #(.ADDR_W(32)) ifc ();
  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(ifc.master));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    ifc.imem_rvalid = 1'b0;
    ifc.imem_rdata  = 32'h0;
    ifc.instr_ready = 1'b0;
    ifc.PCSrc       = 1'b0;
    ifc.PCTarget    = 32'h0;
  endtask
  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask
  task automatic test_reset();
    idle_inputs();
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'h0050_0093;
    rst = 1'b0;
    step();
    step();
    n_tot++; if (ifc.imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", ifc.imem_req); else n_pass++;
    n_tot++; if (ifc.instr_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", ifc.instr_valid); else n_pass++;
    n_tot++; if (ifc.Instr !== 32'h13) $display("FAIL rst_instr got %h want %h", ifc.Instr, 32'h13); else n_pass++;
    n_tot++; if (ifc.Op !== 7'h13) $display("FAIL rst_op got %h want 13", ifc.Op); else n_pass++;
    n_tot++; if (ifc.instret !== 32'h0) $display("FAIL rst_instret got %h want 0", ifc.instret); else n_pass++;
    n_tot++; if (ifc.fetch_err !== 1'b0) $display("FAIL rst_err got %b want 0", ifc.fetch_err); else n_pass++;
    n_tot++; if (ifc.PC !== 32'h0) $display("FAIL rst_pc got %h want 0", ifc.PC); else n_pass++;
    n_tot++; if (ifc.PCPlus4 !== 32'h4) $display("FAIL rst_pcplus4 got %h want 4", ifc.PCPlus4); else n_pass++;
    rst = 1'b1;
    n_tot++; if (ifc.imem_req !== 1'b0) $display("FAIL idle_req got %b want 0", ifc.imem_req); else n_pass++;
    step();
    n_tot++; if (ifc.imem_req !== 1'b1) $display("FAIL c1_req got %b want 1", ifc.imem_req); else n_pass++;
    n_tot++; if (ifc.imem_addr !== 32'h0) $display("FAIL c1_addr got %h want 0", ifc.imem_addr); else n_pass++;
    n_tot++; if (ifc.instr_valid !== 1'b0) $display("FAIL c1_valid got %b want 0", ifc.instr_valid); else n_pass++;
    n_tot++; if (ifc.Instr !== 32'h13) $display("FAIL c1_instr got %h want %h", ifc.Instr, 32'h13); else n_pass++;
    step();
    ifc.imem_rvalid = 1'b0;
    n_tot++; if (ifc.instr_valid !== 1'b1) $display("FAIL c2_valid got %b want 1", ifc.instr_valid); else n_pass++;
    n_tot++; if (ifc.Instr !== 32'h0050_0093) $display("FAIL c2_instr got %h want %h", ifc.Instr, 32'h0050_0093); else n_pass++;
    n_tot++; if (ifc.imem_req !== 1'b0) $display("FAIL c2_req got %b want 0", ifc.imem_req); else n_pass++;
  endtask
  task automatic test_wait_states();
    do_reset();
    ifc.imem_rdata = 32'h0050_0093;
    step();
    for (int i = 0; i < 4; i++) begin
      n_tot++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h0) $display("FAIL wait_hold[%0d] got req=%b addr=%h want req=1 addr=0", i, ifc.imem_req, ifc.imem_addr); else n_pass++;
      n_tot++; if (ifc.instr_valid !== 1'b0) $display("FAIL wait_valid[%0d] got %b want 0", i, ifc.instr_valid); else n_pass++;
      ifc.imem_rvalid = (i == 3);
      step();
    end
    ifc.imem_rvalid = 1'b0;
    n_tot++; if (ifc.instr_valid !== 1'b1) $display("FAIL wait_valid_after got %b want 1", ifc.instr_valid); else n_pass++;
    n_tot++; if (ifc.Op !== 7'h13) $display("FAIL wait_op got %h want 13", ifc.Op); else n_pass++;
    n_tot++; if (ifc.funct3 !== 3'd0) $display("FAIL wait_funct3 got %h want 0", ifc.funct3); else n_pass++;
    n_tot++; if (ifc.funct7 !== 1'b0) $display("FAIL wait_funct7 got %b want 0", ifc.funct7); else n_pass++;
  endtask
  task automatic test_sequential_retire();
    ifc.instr_ready = 1'b1;
    step();
    ifc.instr_ready = 1'b0;
    n_tot++; if (ifc.imem_addr !== 32'h4) $display("FAIL seq1_addr got %h want 4", ifc.imem_addr); else n_pass++;
    n_tot++; if (ifc.imem_req !== 1'b1 || ifc.instr_valid !== 1'b0) $display("FAIL seq1_hs got req=%b valid=%b want req=1 valid=0", ifc.imem_req, ifc.instr_valid); else n_pass++;
    n_tot++; if (ifc.instret !== 32'd1) $display("FAIL seq1_instret got %0d want 1", ifc.instret); else n_pass++;
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'h0020_8113;
    step();
    ifc.imem_rvalid = 1'b0;
    n_tot++; if (ifc.funct3 !== 3'd0 || ifc.Op !== 7'h13 || ifc.PCPlus4 !== 32'h8) $display("FAIL seq2_fields got f3=%h op=%h pc4=%h want f3=0 op=13 pc4=8", ifc.funct3, ifc.Op, ifc.PCPlus4); else n_pass++;
    ifc.instr_ready = 1'b1;
    step();
    ifc.instr_ready = 1'b0;
    n_tot++; if (ifc.imem_addr !== 32'h8) $display("FAIL seq2_addr got %h want 8", ifc.imem_addr); else n_pass++;
    n_tot++; if (ifc.instret !== 32'd2) $display("FAIL seq2_instret got %0d want 2", ifc.instret); else n_pass++;
  endtask
  task automatic test_branch();
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'h4000_0033;
    step();
    ifc.imem_rvalid = 1'b0;
    n_tot++; if (ifc.Op !== 7'h33 || ifc.funct7 !== 1'b1) $display("FAIL br_fields got op=%h f7=%b want op=33 f7=1", ifc.Op, ifc.funct7); else n_pass++;
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'hDEAD_BEEF;
    ifc.PCSrc       = 1'b1;
    ifc.PCTarget    = 32'h200;
    step();
    ifc.imem_rvalid = 1'b0;
    n_tot++; if (ifc.Instr !== 32'h4000_0033) $display("FAIL br_stray_instr got %h want %h", ifc.Instr, 32'h4000_0033); else n_pass++;
    n_tot++; if (ifc.instr_valid !== 1'b1 || ifc.PC !== 32'h8) $display("FAIL br_hold got valid=%b pc=%h want valid=1 pc=8", ifc.instr_valid, ifc.PC); else n_pass++;
    ifc.instr_ready = 1'b1;
    ifc.PCTarget    = 32'h100;
    step();
    n_tot++; if (ifc.imem_addr !== 32'h100) $display("FAIL br_addr got %h want 100", ifc.imem_addr); else n_pass++;
    n_tot++; if (ifc.instret !== 32'd3) $display("FAIL br_instret got %0d want 3", ifc.instret); else n_pass++;
    ifc.PCTarget = 32'h300;
    step();
    ifc.instr_ready = 1'b0;
    ifc.PCSrc       = 1'b0;
    n_tot++; if (ifc.imem_addr !== 32'h100 || ifc.imem_req !== 1'b1) $display("FAIL fetch_ignores_ready got addr=%h req=%b want addr=100 req=1", ifc.imem_addr, ifc.imem_req); else n_pass++;
    n_tot++; if (ifc.instret !== 32'd3) $display("FAIL fetch_ignores_instret got %0d want 3", ifc.instret); else n_pass++;
  endtask
  task automatic test_wrap();
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'h0000_006F;
    step();
    ifc.imem_rvalid = 1'b0;
    ifc.instr_ready = 1'b1;
    ifc.PCSrc       = 1'b1;
    ifc.PCTarget    = 32'hFFFF_FFFC;
    step();
    ifc.instr_ready = 1'b0;
    ifc.PCSrc       = 1'b0;
    n_tot++; if (ifc.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got %h want fffffffc", ifc.imem_addr); else n_pass++;
    n_tot++; if (ifc.PCPlus4 !== 32'h0) $display("FAIL wrap_pcplus4 got %h want 0", ifc.PCPlus4); else n_pass++;
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'h13;
    step();
    ifc.imem_rvalid = 1'b0;
    ifc.instr_ready = 1'b1;
    step();
    ifc.instr_ready = 1'b0;
    n_tot++; if (ifc.imem_addr !== 32'h0) $display("FAIL wrap_next got %h want 0", ifc.imem_addr); else n_pass++;
    n_tot++; if (ifc.instret !== 32'd5) $display("FAIL wrap_instret got %0d want 5", ifc.instret); else n_pass++;
  endtask
  task automatic test_misalign();
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'h0000_006F;
    step();
    ifc.imem_rvalid = 1'b0;
    ifc.instr_ready = 1'b1;
    ifc.PCSrc       = 1'b1;
    ifc.PCTarget    = 32'h102;
    step();
    ifc.PCSrc = 1'b0;
    n_tot++; if (ifc.fetch_err !== 1'b1) $display("FAIL mis_err got %b want 1", ifc.fetch_err); else n_pass++;
    n_tot++; if (ifc.instret !== 32'd6) $display("FAIL mis_instret got %0d want 6", ifc.instret); else n_pass++;
    ifc.imem_rvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_tot++; if (ifc.imem_req !== 1'b0 || ifc.instr_valid !== 1'b0) $display("FAIL halt[%0d] got req=%b valid=%b want 0 0", i, ifc.imem_req, ifc.instr_valid); else n_pass++;
      step();
    end
    ifc.imem_rvalid = 1'b0;
    ifc.instr_ready = 1'b0;
    n_tot++; if (ifc.PC !== 32'h0) $display("FAIL halt_pc got %h want 0", ifc.PC); else n_pass++;
    n_tot++; if (ifc.fetch_err !== 1'b1 || ifc.instret !== 32'd6) $display("FAIL halt_sticky got err=%b instret=%0d want 1 6", ifc.fetch_err, ifc.instret); else n_pass++;
  endtask
  task automatic test_async_reset();
    do_reset();
    n_tot++; if (ifc.fetch_err !== 1'b0) $display("FAIL areset_err got %b want 0", ifc.fetch_err); else n_pass++;
    step();
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'h0050_0093;
    step();
    ifc.imem_rvalid = 1'b0;
    ifc.instr_ready = 1'b1;
    step();
    ifc.instr_ready = 1'b0;
    n_tot++; if (ifc.imem_addr !== 32'h4 || ifc.instret !== 32'd1) $display("FAIL areset_pre got addr=%h instret=%0d want 4 1", ifc.imem_addr, ifc.instret); else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_tot++; if (ifc.imem_req !== 1'b0 || ifc.instr_valid !== 1'b0) $display("FAIL areset_hs got req=%b valid=%b want 0 0", ifc.imem_req, ifc.instr_valid); else n_pass++;
    n_tot++; if (ifc.PC !== 32'h0 || ifc.instret !== 32'd0) $display("FAIL areset_regs got pc=%h instret=%0d want 0 0", ifc.PC, ifc.instret); else n_pass++;
    n_tot++; if (ifc.Instr !== 32'h13) $display("FAIL areset_instr got %h want %h", ifc.Instr, 32'h13); else n_pass++;
    #1;
    rst = 1'b1;
    step();
    n_tot++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h0) $display("FAIL areset_restart got req=%b addr=%h want 1 0", ifc.imem_req, ifc.imem_addr); else n_pass++;
  endtask
  initial begin
    n_pass = 0;
    n_tot  = 0;
    rst    = 1'b0;
    idle_inputs();
    test_reset();
    test_wait_states();
    test_sequential_retire();
    test_branch();
    test_wrap();
    test_misalign();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
